p7_timer: RTL and testbench
===========================

// Module: p7_timer
// PURPOSE
//   Memory-mapped countdown timer. It is the responder end of the CPU data bus
//   (m_data_addr/m_data_wdata/m_data_byteen/m_data_rdata). It drives one of the
//   CPU's timer interrupt inputs (tIBQ0 or tIBQ1).
//   One instance sits at 0x7F00-0x7F0B and a second at 0x7F10-0x7F1B. The bus
//   bridge decodes the base address and asserts sel.
// PARAMETERS
//   PRESCALE   4   tick divider, used only when TIMER_PRESCALE_EN is defined (>=1)
// PORTS
//   clk      in   1   system clock, all state updates on posedge
//   reset    in   1   synchronous, active-high
//   sel      in   1   bridge decode: this timer is addressed this cycle
//   addr     in   32  byte address; only addr[3:2] decoded (0=CTRL, 1=PRESET, 2=COUNT, 3=reads 0)
//   byteen   in   4   write byte enables; a write happens only when sel && byteen==4'b1111
//   din      in   32  write data
//   dout     out  32  read data, combinational from addr[3:2] (same-cycle, M stage)
//   irq      out  1   interrupt request to CPU, = CTRL.IM & irq_flag, registered
// BEHAVIOUR
//   Registers
//   - CTRL: [0]=EN, [2:1]=MODE, [3]=IM; bits [31:4] read 0, writes ignored.
//   - PRESET: 32b, R/W.
//   - COUNT: 32b, read-only; writes to it are silently dropped.
//   - Partial-byteen writes are ignored (the CPU raises AdES before they arrive).
//   Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0.
//   - dout is still driven combinationally from addr during reset.
//   FSM (states IDLE, LOAD, CNT, INT), one transition per clock:
//   - IDLE: if EN -> LOAD.
//   - LOAD: COUNT<=PRESET -> CNT.
//   - CNT:
//       - if !EN -> IDLE, COUNT holds.
//       - elif COUNT>1 -> COUNT-1.
//       - else COUNT<=0, irq_flag<=1 -> INT.
//   - INT, MODE=00 (one-shot): EN<=0 -> IDLE. irq_flag stays 1 until a CTRL or PRESET write.
//   - INT, MODE=01 (auto-reload): irq_flag<=0 -> IDLE. Because EN is still 1, it reloads.
//       - irq is therefore high for exactly one cycle per period.
//       - Period = PRESET+3 cycles (PRESET>=1).
//   - MODE=1x: treated as 00.
//   Boundaries and simultaneous events:
//   - PRESET=0 behaves as PRESET=1: INT is reached one cycle after LOAD.
//   - A write in cycle N is seen by the FSM in cycle N+1.
//   - A CTRL write coinciding with the INT clear of EN wins; the written EN is kept.
//   - A CTRL or PRESET write clears irq_flag in the same edge. This takes priority over
//     the flag being set by CNT->INT.
//   - Writing EN=0 mid-count freezes COUNT. The next EN=1 restarts from LOAD, not from
//     the frozen COUNT.
//   - COUNT never wraps below 0.
//   - reset asserted mid-count: all state returns to reset values on that edge.
// CONFIGURATION
//   TIMER_PRESCALE_EN defined:
//   - A prescale counter 0..PRESCALE-1 gates the CNT decrement. It also gates the
//     CNT->INT step.
//   - The prescaler clears on LOAD and on reset.
//   - Period = PRESET*PRESCALE+3 cycles.
//   TIMER_PRESCALE_EN undefined: no prescaler; CNT decrements every cycle; PRESCALE is unused.
// TESTING
//   1. Reset, then read CTRL/PRESET/COUNT -> 0 each; irq=0.
//   2. PRESET=5, CTRL=0x9 (EN, mode0, IM):
//        -> COUNT reads 5,4,3,2,1,0;
//        -> irq rises 1 cycle after COUNT=0 and holds;
//        -> CTRL reads 0x8.
//      Then write PRESET=5 -> irq falls on the next edge.
//   3. PRESET=2, CTRL=0xB (mode1, IM):
//        -> irq pulses 1 cycle wide, every 5 cycles, for 3 periods.
//      Write CTRL=0x3 -> counting continues and irq stays 0.
//   4. PRESET=10, EN=1; after 4 decrements write CTRL=0:
//        -> COUNT frozen at 6.
//      Write CTRL=0x9 -> COUNT reloads to 10.
//   5. Write COUNT=0x1234, and do a byteen=4'b0011 write to PRESET:
//        -> all registers are unchanged.
//      Write to addr[3:2]=3 -> reads 0.
//   6. Assert reset while in CNT with irq=1 -> next cycle all registers=0 and irq=0.
//      With TIMER_PRESCALE_EN and PRESCALE=4, PRESET=2 mode1 -> the period is 11 cycles.

Source files
------------

// File: rtl/p7_timer_if.sv
// Bus bundle between the data-bus bridge and one p7_timer instance.
// The bridge drives sel/addr/byteen/din; the timer returns dout and irq.
interface p7_timer_if;
    logic        sel;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output sel, addr, byteen, din, input dout, irq);
    modport slave  (input sel, addr, byteen, din, output dout, irq);
endinterface

// File: rtl/p7_timer.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Optional tick prescaler is enabled by defining TIMER_PRESCALE_EN.
module p7_timer #(
    parameter int PRESCALE = 4
) (
    input  logic      clk,
    input  logic      reset,
    p7_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state;
    state_t      state_next;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_next;
    logic        irq_flag;
    logic        irq_r;
    logic        we;
    logic        ctrl_we;
    logic        preset_we;
    logic        flag_set;
    logic        flag_clr;
    logic        en_clr;
    logic        tick;
    logic        unused_addr;

    assign we          = bus.sel && (bus.byteen == 4'b1111);
    assign ctrl_we     = we && (bus.addr[3:2] == 2'd0);
    assign preset_we   = we && (bus.addr[3:2] == 2'd1);
    assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre;
    logic [PW-1:0] pre_next;

    assign tick = (pre == PW'(PRESCALE - 1));

    always_comb begin
        pre_next = pre;
        if (state == LOAD)
            pre_next = '0;
        else if (state == CNT && en)
            pre_next = tick ? '0 : pre + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pre <= '0;
        else
            pre <= pre_next;
    end
`else
    logic unused_prescale;
    assign tick            = 1'b1;
    assign unused_prescale = (PRESCALE != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // COUNT stops at 0 rather than wrapping; PRESET=0 therefore acts like PRESET=1.
    always_comb begin
        state_next = state;
        count_next = count;
        flag_set   = 1'b0;
        flag_clr   = 1'b0;
        en_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (en)
                    state_next = LOAD;
            end
            LOAD: begin
                count_next = preset;
                state_next = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (count > 32'd1) begin
                        count_next = count - 32'd1;
                    end else begin
                        count_next = '0;
                        flag_set   = 1'b1;
                        state_next = INT;
                    end
                end
            end
            INT: begin
                state_next = IDLE;
                if (mode == 2'b01)
                    flag_clr = 1'b1;
                else
                    en_clr = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus writes override the FSM: a CTRL write keeps its EN, and any CTRL/PRESET write clears the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b0;
            mode     <= 2'b00;
            im       <= 1'b0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            count <= count_next;
            irq_r <= im & irq_flag;
            if (ctrl_we) begin
                en   <= bus.din[0];
                mode <= bus.din[2:1];
                im   <= bus.din[3];
            end else if (en_clr) begin
                en <= 1'b0;
            end
            if (preset_we)
                preset <= bus.din;
            if (ctrl_we || preset_we)
                irq_flag <= 1'b0;
            else if (flag_set)
                irq_flag <= 1'b1;
            else if (flag_clr)
                irq_flag <= 1'b0;
        end
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr[3:2])
            2'd0:    bus.dout = {28'd0, im, mode, en};
            2'd1:    bus.dout = preset;
            2'd2:    bus.dout = count;
            default: bus.dout = '0;
        endcase
    end

    assign bus.irq = irq_r;

endmodule

// File: tb/tb_p7_timer.sv
// Randomized bench for p7_timer; expected COUNT/irq timing comes from closed-form period arithmetic.
// Follows TIMER_PRESCALE_EN the same way the design does.
module tb_p7_timer;
    localparam int PRESCALE = 4;
`ifdef TIMER_PRESCALE_EN
    localparam int PS = PRESCALE;
`else
    localparam int PS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] base;
    int          checks = 0;
    int          errors = 0;

    p7_timer_if bus ();

    p7_timer #(.PRESCALE(PRESCALE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected COUNT s edges after the enabling CTRL write: PRESET at s=2, one step per PS cycles, floor 0.
    function automatic logic [31:0] exp_count(input int p, input int s);
        int k;
        k = p - (s - 2) / PS;
        return (k < 0) ? 32'd0 : 32'(k);
    endfunction

    // Edge count from the enabling write to irq rising (= auto-reload period).
    function automatic int fire(input int p);
        return ((p < 1) ? 1 : p) * PS + 3;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [31:0] data, input logic [3:0] be);
        bus.sel    = 1'b1;
        bus.addr   = base | {28'd0, idx, 2'b00};
        bus.byteen = be;
        bus.din    = data;
        @(negedge clk);
        bus.sel    = 1'b0;
        bus.byteen = 4'b0000;
    endtask

    task automatic rd(input logic [1:0] idx, output logic [31:0] d);
        bus.addr = base | {28'd0, idx, 2'b00};
        #1;
        d = bus.dout;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        base  = ($urandom_range(0, 1) == 1) ? 32'h0000_7F10 : 32'h0000_7F00;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_reg%0d: got %h, required %h", i, d, 32'd0);
            end
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_irq: got %b, required 0", bus.irq);
        end
    endtask

    task automatic test_oneshot(input int p);
        logic [31:0] d;
        int rise;
        do_reset();
        rise = fire(p);
        wr(2'd1, 32'(p), 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        for (int s = 0; s <= rise + 3; s++) begin
            rd(2'd2, d);
            if (s >= 2) begin
                checks++;
                if (d !== exp_count(p, s)) begin
                    errors++;
                    $display("[TB] FAIL oneshot_count p=%0d s=%0d: got %0d, required %0d", p, s, d, exp_count(p, s));
                end
            end
            checks++;
            if (bus.irq !== (s >= rise)) begin
                errors++;
                $display("[TB] FAIL oneshot_irq p=%0d s=%0d: got %b, required %b", p, s, bus.irq, (s >= rise));
            end
            tick(1);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h8) begin
            errors++;
            $display("[TB] FAIL oneshot_ctrl p=%0d: got %h, required %h", p, d, 32'h8);
        end
        wr(2'd1, 32'(p), 4'hF);
        tick(1);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oneshot_irq_clear p=%0d: got %b, required 0", p, bus.irq);
        end
    endtask

    task automatic test_autoreload(input int p);
        logic [31:0] d;
        logic        exp_i;
        logic        saw;
        int          per;
        do_reset();
        per = fire(p);
        wr(2'd1, 32'(p), 4'hF);
        wr(2'd0, 32'hB, 4'hF);
        for (int s = 0; s <= 3 * per; s++) begin
            exp_i = (s >= per) && ((s - per) % per == 0);
            checks++;
            if (bus.irq !== exp_i) begin
                errors++;
                $display("[TB] FAIL reload_irq p=%0d s=%0d: got %b, required %b", p, s, bus.irq, exp_i);
            end
            tick(1);
        end
        wr(2'd0, 32'h3, 4'hF);
        saw = 1'b0;
        for (int s = 0; s <= 2 * per; s++) begin
            rd(2'd2, d);
            if (d == 32'(p))
                saw = 1'b1;
            if (s >= 1) begin
                checks++;
                if (bus.irq !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reload_masked_irq p=%0d s=%0d: got %b, required 0", p, s, bus.irq);
                end
            end
            tick(1);
        end
        checks++;
        if (saw !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reload_keeps_counting p=%0d: reload seen %b, required 1", p, saw);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h3) begin
            errors++;
            $display("[TB] FAIL reload_ctrl p=%0d: got %h, required %h", p, d, 32'h3);
        end
    endtask

    task automatic test_freeze();
        logic [31:0] d;
        logic [31:0] exp_d;
        do_reset();
        wr(2'd1, 32'd10, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        tick(1 + 4 * PS);
        wr(2'd0, 32'h0, 4'hF);
        for (int s = 0; s < 5; s++) begin
            rd(2'd2, d);
            checks++;
            if (d !== 32'd6) begin
                errors++;
                $display("[TB] FAIL freeze_count s=%0d: got %0d, required 6", s, d);
            end
            tick(1);
        end
        wr(2'd0, 32'h9, 4'hF);
        for (int s = 0; s <= 2; s++) begin
            exp_d = (s < 2) ? 32'd6 : 32'd10;
            rd(2'd2, d);
            checks++;
            if (d !== exp_d) begin
                errors++;
                $display("[TB] FAIL restart_count s=%0d: got %0d, required %0d", s, d, exp_d);
            end
            tick(1);
        end
    endtask

    task automatic test_bus_rules();
        logic [31:0] d;
        logic [31:0] r;
        logic [3:0]  partial [4];
        partial[0] = 4'b0011;
        partial[1] = 4'b0001;
        partial[2] = 4'b1110;
        partial[3] = 4'b0111;
        do_reset();
        r = $urandom;
        wr(2'd1, r, 4'hF);
        wr(2'd0, 32'hFFFF_FFF6, 4'hF);
        rd(2'd0, d);
        checks++;
        if (d !== 32'h6) begin
            errors++;
            $display("[TB] FAIL ctrl_upper_bits: got %h, required %h", d, 32'h6);
        end
        wr(2'd2, 32'h1234, 4'hF);
        wr(2'd1, ~r, 4'b0011);
        wr(2'd0, 32'h9, partial[$urandom_range(0, 3)]);
        wr(2'd3, $urandom, 4'hF);
        rd(2'd1, d);
        checks++;
        if (d !== r) begin
            errors++;
            $display("[TB] FAIL partial_preset: got %h, required %h", d, r);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h6) begin
            errors++;
            $display("[TB] FAIL partial_ctrl: got %h, required %h", d, 32'h6);
        end
        rd(2'd2, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL count_readonly: got %h, required %h", d, 32'd0);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reg3_reads_zero: got %h, required %h", d, 32'd0);
        end
    endtask

    task automatic test_priority(input int p);
        logic [31:0] d;
        int f;
        f = fire(p);
        // CTRL write on the same edge that INT clears EN: the written EN survives.
        do_reset();
        wr(2'd1, 32'(p), 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick(f - 1);
        wr(2'd0, 32'h9, 4'hF);
        rd(2'd0, d);
        checks++;
        if (d !== 32'h9) begin
            errors++;
            $display("[TB] FAIL int_ctrl_write_wins: got %h, required %h", d, 32'h9);
        end
        tick(1);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL int_ctrl_write_clears_flag: got %b, required 0", bus.irq);
        end
        tick(1);
        rd(2'd2, d);
        checks++;
        if (d !== 32'(p)) begin
            errors++;
            $display("[TB] FAIL int_ctrl_write_reload: got %0d, required %0d", d, p);
        end
        // PRESET write on the CNT->INT edge: the clear beats the set.
        do_reset();
        wr(2'd1, 32'(p), 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick(f - 2);
        wr(2'd1, 32'(p), 4'hF);
        for (int s = 0; s < 6; s++) begin
            checks++;
            if (bus.irq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flag_clear_priority s=%0d: got %b, required 0", s, bus.irq);
            end
            tick(1);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h8) begin
            errors++;
            $display("[TB] FAIL flag_clear_int_taken: got %h, required %h", d, 32'h8);
        end
    endtask

    task automatic test_midreset(input int p);
        logic [31:0] d;
        int n;
        do_reset();
        wr(2'd1, 32'(p), 4'hF);
        wr(2'd0, 32'hB, 4'hF);
        n = 0;
        while (bus.irq !== 1'b1 && n < 500) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("[TB] FAIL midreset_wait_irq: got timeout after %0d cycles, required irq=1", n);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(2'(i), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("[TB] FAIL midreset_reg%0d: got %h, required %h", i, d, 32'd0);
            end
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_irq: got %b, required 0", bus.irq);
        end
        wr(2'd1, 32'(p), 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        rd(2'd2, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midcount_reset_count: got %0d, required 0", d);
        end
    endtask

    initial begin
        reset      = 1'b1;
        base       = 32'h0000_7F00;
        bus.sel    = 1'b0;
        bus.addr   = '0;
        bus.byteen = 4'b0000;
        bus.din    = '0;
        test_reset();
        test_oneshot(5);
        test_oneshot(0);
        repeat (3) test_oneshot(int'($urandom_range(1, 12)));
        test_autoreload(2);
        repeat (2) test_autoreload(int'($urandom_range(1, 6)));
        test_freeze();
        test_bus_rules();
        test_priority(int'($urandom_range(2, 8)));
        test_midreset(int'($urandom_range(3, 8)));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
